// File: rtl/ascon_aead128_pkg.sv
// Shared types and constants for the ascon core scheduler.
package ascon_aead128_pkg;

  localparam int unsigned BLK_W_DEF    = 128;
  localparam int unsigned WDOG_CYC_DEF = 64;
  localparam int unsigned WDOG_W       = $clog2(WDOG_CYC_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    FEED_AD,
    FEED_DB,
    WAIT_TAG,
    RELEASE,
    ERR
  } sched_state;

  typedef logic [1:0] client_oh;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; the pointer moves to the other client on update_i.
module rr_arbiter2
  import ascon_aead128_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  client_oh req_i,
  input  logic     update_i,
  input  logic     owner_idx_i,
  output client_oh gnt_c_o
);

  logic ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_i) ptr_d = ~owner_idx_i;
  end

  // Single requester wins outright; a tie goes to the pointer.
  always_comb begin
    gnt_c_o = 2'b00;
    case (req_i)
      2'b01:   gnt_c_o = 2'b01;
      2'b10:   gnt_c_o = 2'b10;
      2'b11:   gnt_c_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_c_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ascon_core_scheduler.sv
// Shares one ascon_aead128 core between two clients, one whole message at a time.
module ascon_core_scheduler
  import ascon_aead128_pkg::*;
#(
  parameter int unsigned BLK_W    = BLK_W_DEF,
  parameter int unsigned WDOG_CYC = WDOG_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cli_req_i,
  input  logic [1:0]       cli_valid_i,
  input  logic [1:0]       cli_is_ad_i,
  input  logic [1:0]       cli_last_i,
  input  logic [BLK_W-1:0] cli_data0_i,
  input  logic [BLK_W-1:0] cli_data1_i,
  output logic [1:0]       cli_ready_o,
  output logic [1:0]       cli_grant_o,
  output logic [1:0]       cli_dout_vld_o,
  output logic [1:0]       cli_tag_vld_o,
  output logic             core_start_o,
  output logic             core_vld_ad_o,
  output logic             core_vld_db_o,
  output logic [BLK_W-1:0] core_din_o,
  input  logic             core_ready_i,
  input  logic             core_dout_v_i,
  input  logic             core_tag_v_i,
  output logic             err_o
);

  localparam int unsigned CNT_W = $clog2(WDOG_CYC + 1);

  sched_state       state_q, state_d;
  client_oh         grant_q, grant_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [BLK_W-1:0] din_q;

  client_oh arb_gnt;
  logic     arb_update;
  logic     accept;
  logic     fault;
  logic     own_req, own_vld, own_ad, own_last;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (cli_req_i),
    .update_i    (arb_update),
    .owner_idx_i (grant_q[1]),
    .gnt_c_o     (arb_gnt)
  );

  assign own_req  = |(cli_req_i   & grant_q);
  assign own_vld  = |(cli_valid_i & grant_q);
  assign own_ad   = |(cli_is_ad_i & grant_q);
  assign own_last = |(cli_last_i  & grant_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      err_q   <= 1'b0;
      wdog_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
      din_q   <= core_din_o;
    end
  end

  // Next state and core handshake decode.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    err_d         = err_q;
    wdog_d        = wdog_q;
    arb_update    = 1'b0;
    accept        = 1'b0;
    fault         = 1'b0;
    core_start_o  = 1'b0;
    core_vld_ad_o = 1'b0;
    core_vld_db_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (|cli_req_i) begin
          grant_d = arb_gnt;
          state_d = KICK;
        end
      end
      KICK: begin
        core_start_o = 1'b1;
        wdog_d       = '0;
        if (!own_req) fault = 1'b1;
        else          state_d = FEED_AD;
      end
      FEED_AD, FEED_DB: begin
        core_start_o = 1'b1;
        if (!own_req) begin
          fault = 1'b1;
        end else if (own_vld && own_ad && (state_q == FEED_DB)) begin
          fault = 1'b1;
        end else if (own_vld && core_ready_i) begin
          accept = 1'b1;
          wdog_d = '0;
          if (own_ad) begin
            core_vld_ad_o = 1'b1;
          end else begin
            // A data block in FEED_AD is taken on the FEED_DB path directly.
            core_vld_db_o = 1'b1;
            core_start_o  = ~own_last;
            state_d       = own_last ? WAIT_TAG : FEED_DB;
          end
        end else if (own_vld) begin
          wdog_d = wdog_q + CNT_W'(1);
          if (wdog_d == CNT_W'(WDOG_CYC)) fault = 1'b1;
        end
      end
      WAIT_TAG: begin
        if (core_tag_v_i) state_d = RELEASE;
      end
      RELEASE: begin
        grant_d    = 2'b00;
        arb_update = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = ERR;
    endcase
    if (fault) begin
      state_d = ERR;
      err_d   = 1'b1;
      grant_d = 2'b00;
    end
  end

  assign cli_ready_o    = accept ? grant_q : 2'b00;
  assign cli_grant_o    = grant_q;
  assign cli_dout_vld_o = {2{core_dout_v_i}} & grant_q;
  assign cli_tag_vld_o  = {2{core_tag_v_i}} & grant_q;
  assign err_o          = err_q;

  // Without an owner the core keeps seeing the previous block.
  assign core_din_o = (|grant_q) ? (grant_q[1] ? cli_data1_i : cli_data0_i) : din_q;

endmodule

// File: tb/tb_ascon_core_scheduler.sv
// Directed bench for ascon_core_scheduler with hand-derived expectations.
module tb_ascon_core_scheduler;

  localparam int unsigned BW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req, valid, is_ad, last;
  logic [BW-1:0] d0, d1;
  logic          c_rdy, c_dout, c_tag;
  logic [1:0]    cli_ready, grant, dout_vld, tag_vld;
  logic          start, vld_ad, vld_db, err;
  logic [BW-1:0] din;
  logic [BW-1:0] last_d;
  int            n_chk = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  ascon_core_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cli_req_i      (req),
    .cli_valid_i    (valid),
    .cli_is_ad_i    (is_ad),
    .cli_last_i     (last),
    .cli_data0_i    (d0),
    .cli_data1_i    (d1),
    .cli_ready_o    (cli_ready),
    .cli_grant_o    (grant),
    .cli_dout_vld_o (dout_vld),
    .cli_tag_vld_o  (tag_vld),
    .core_start_o   (start),
    .core_vld_ad_o  (vld_ad),
    .core_vld_db_o  (vld_db),
    .core_din_o     (din),
    .core_ready_i   (c_rdy),
    .core_dout_v_i  (c_dout),
    .core_tag_v_i   (c_tag),
    .err_o          (err)
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 2'b00; valid = 2'b00; is_ad = 2'b00; last = 2'b00;
    c_rdy = 1'b0; c_dout = 1'b0; c_tag = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [BW-1:0] pat(input int c, input int i, input bit ad);
    return {64'hC0DE_0000_0000_0000 | 64'(c), (64'(i) << 1) | 64'(ad)};
  endfunction

  // Present one block, hold core_ready low for gap cycles, then accept it.
  task automatic send_blk(input int c, input bit ad, input bit lst, input int i, input int gap);
    logic [BW-1:0] d;
    d = pat(c, i, ad);
    last_d = d;
    valid[c] = 1'b1; is_ad[c] = ad; last[c] = lst;
    if (c == 0) d0 = d; else d1 = d;
    c_rdy = 1'b0;
    for (int g = 0; g < gap; g++) begin
      #1;
      chk("gap_vld", {vld_ad, vld_db}, 2'b00);
      chk("gap_ready", cli_ready, 2'b00);
      chk("gap_start", start, 1'b1);
      step();
    end
    c_rdy = 1'b1;
    #1;
    chk("vld_ad", vld_ad, ad);
    chk("vld_db", vld_db, !ad);
    chk("cli_ready", cli_ready, (c == 1) ? 2'b10 : 2'b01);
    chk("core_din", din, d);
    chk("blk_start", start, !(!ad && lst));
    step();
    valid[c] = 1'b0;
    c_rdy = 1'b0;
  endtask

  // Runs a whole message from the IDLE cycle to the following IDLE cycle.
  task automatic run_msg(input int c, input int n_ad, input int n_db, input int gap, input bit rereq);
    logic [1:0] oh;
    oh = (c == 1) ? 2'b10 : 2'b01;
    step();
    #1;
    chk("kick_grant", grant, oh);
    chk("kick_start", start, 1'b1);
    chk("kick_vld", {vld_ad, vld_db}, 2'b00);
    step();
    for (int i = 0; i < n_ad; i++) send_blk(c, 1'b1, 1'b0, i, gap);
    for (int i = 0; i < n_db; i++) send_blk(c, 1'b0, i == n_db - 1, i, gap);
    #1;
    chk("wait_start", start, 1'b0);
    chk("wait_grant", grant, oh);
    c_dout = 1'b1;
    #1;
    chk("dout_route", dout_vld, oh);
    c_dout = 1'b0;
    c_tag = 1'b1;
    #1;
    chk("tag_route", tag_vld, oh);
    step();
    c_tag = 1'b0;
    if (!rereq) req[c] = 1'b0;
    #1;
    chk("rel_grant", grant, oh);
    chk("rel_tag", tag_vld, 2'b00);
    step();
    #1;
    chk("idle_grant", grant, 2'b00);
    chk("idle_start", start, 1'b0);
    chk("din_hold", din, last_d);
  endtask

  initial begin
    d0 = '0; d1 = '0; last_d = '0;
    do_reset();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_vld", {vld_ad, vld_db, cli_ready}, 4'h0);
    chk("rst_din", din, '0);

    // Single client 0, 2 AD + 3 data, 5-cycle ready gaps.
    req = 2'b01;
    run_msg(0, 2, 3, 5, 1'b0);

    // Tie after reset goes to client 0; client 1 noise is never accepted.
    do_reset();
    req = 2'b11;
    valid[1] = 1'b1; is_ad[1] = 1'b1; d1 = pat(1, 9, 1'b1);
    run_msg(0, 1, 2, 1, 1'b0);
    valid[1] = 1'b0;
    run_msg(1, 1, 1, 2, 1'b0);

    // Client 0 re-requests in RELEASE while client 1 waits; client 1 goes next.
    req = 2'b11;
    run_msg(0, 1, 1, 0, 1'b1);
    run_msg(1, 1, 1, 0, 1'b0);
    req = 2'b00;
    step();

    // AD after a data block for client 1 is a protocol error.
    req = 2'b10;
    step();
    step();
    send_blk(1, 1'b1, 1'b0, 0, 0);
    send_blk(1, 1'b0, 1'b0, 0, 0);
    valid[1] = 1'b1; is_ad[1] = 1'b1; c_rdy = 1'b1;
    #1;
    chk("aderr_vld", {vld_ad, vld_db}, 2'b00);
    chk("aderr_ready", cli_ready, 2'b00);
    step();
    #1;
    chk("err_set", err, 1'b1);
    chk("err_grant", grant, 2'b00);
    chk("err_start", start, 1'b0);
    chk("err_quiet", {vld_ad, vld_db, cli_ready}, 4'h0);
    c_dout = 1'b1; c_tag = 1'b1;
    #1;
    chk("err_route", {dout_vld, tag_vld}, 4'h0);
    c_dout = 1'b0; c_tag = 1'b0;
    repeat (3) step();
    chk("err_sticky", err, 1'b1);
    chk("err_sticky_grant", grant, 2'b00);

    // Watchdog fires on the 64th stalled cycle, not the 63rd.
    do_reset();
    req = 2'b01;
    step();
    step();
    valid[0] = 1'b1; is_ad[0] = 1'b1; c_rdy = 1'b0;
    repeat (63) step();
    chk("wdog_63", err, 1'b0);
    chk("wdog_63_grant", grant, 2'b01);
    step();
    chk("wdog_64", err, 1'b1);
    chk("wdog_64_grant", grant, 2'b00);

    // Reset in FEED_DB abandons the message; client 1 then completes.
    do_reset();
    req = 2'b01;
    step();
    step();
    send_blk(0, 1'b1, 1'b0, 0, 0);
    send_blk(0, 1'b0, 1'b0, 0, 0);
    valid[0] = 1'b1; is_ad[0] = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mrst_grant", grant, 2'b00);
    chk("mrst_start", start, 1'b0);
    chk("mrst_err", err, 1'b0);
    chk("mrst_din", din, '0);
    rst_n = 1'b1; req = 2'b10; valid = 2'b00;
    run_msg(1, 1, 2, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
